count_wrap_monitor: RTL and testbench
=====================================

Name: count_wrap_monitor

Overview:
- Downstream observer of the 4-bit up/down counter; samples the counter output and the direction input each clock.
- Detects wrap-around events (MAX->0 counting up, 0->MAX counting down) and direction changes.
- Keeps a saturating wrap tally, running min/max of the count, and a sticky step-error flag for non-unit jumps.
- Feeds the display/debug stage; purely observes and never drives the counter.

Parameters:
- WIDTH, 4, width of the observed count; MAX = 2**WIDTH-1.
- WRAP_CNT_W, 8, width of the wrap tally; saturates at 2**WRAP_CNT_W-1.

Ports:
- clock_signal  input  1  system clock; all state on rising edge.
- reset_signal  input  1  asynchronous, active-high reset; shared with the counter.
- up_down  input  1  counter direction, same net as the counter's; 1 = up, 0 = down.
- count_in  input  WIDTH  counter output.
- clear_stats  input  1  synchronous clear of all statistics; returns to IDLE.
- wrap_pulse  output  1  one-cycle pulse per detected wrap.
- wrap_up  output  1  valid with wrap_pulse; 1 = MAX->0, 0 = 0->MAX.
- dir_change  output  1  one-cycle pulse when the sampled up_down differs from the previous sample.
- wrap_count  output  WRAP_CNT_W  saturating count of wraps.
- min_seen  output  WIDTH  smallest count sampled since arm.
- max_seen  output  WIDTH  largest count sampled since arm.
- step_error  output  1  sticky; set when count moved by anything other than 0 or ±1 (mod 2**WIDTH) in the sampled direction.

Behaviour:
- Reset (async, immediate):
  - State = IDLE.
  - wrap_pulse, wrap_up, dir_change, step_error = 0; wrap_count = 0; min_seen = 0; max_seen = 0.
  - prev_count = 0; prev_dir = 0.
- Two-state FSM:
  - IDLE: on the next rising edge, capture prev_count = count_in, prev_dir = up_down, min_seen = max_seen = count_in; go to TRACK; no pulses.
  - TRACK, per edge with c = count_in, p = prev_count, d = prev_dir:
    - Up wrap: d==1 && p==MAX && c==0 -> wrap_pulse = 1, wrap_up = 1.
    - Down wrap: d==0 && p==0 && c==MAX -> wrap_pulse = 1, wrap_up = 0.
    - Legal step: c==p, or c==p+1 mod 2**WIDTH when d==1, or c==p-1 mod 2**WIDTH when d==0. Anything else sets step_error, which stays set until reset or clear_stats. A wrap is a legal step.
    - dir_change = (up_down != d).
    - min_seen = min(min_seen, c); max_seen = max(max_seen, c), unsigned compare.
    - wrap_count increments on each wrap_pulse and holds at its maximum.
    - prev_count = c; prev_dir = up_down.
- Timing and latency:
  - All outputs are registered.
  - Pulses appear exactly one clock after the edge at which count_in shows the post-wrap value.
  - Pulses are low on every cycle without a new event.
- clear_stats (synchronous):
  - Same effect as reset, applied at the edge; FSM goes to IDLE.
  - Takes priority over any event detected in the same cycle; no pulse is emitted.
- Counter reset mid-run: the shared reset_signal re-arms the monitor, so a counter reset from 15 to 0 is never reported as a wrap.
- Held count (counter idle): no pulses, no error.
- The direction relation uses the previously sampled up_down, matching the counter, which applies the direction on the same edge.

Decomposition:
- Shared package holds:
  - state enum {IDLE, TRACK};
  - DIR_UP = 1'b1, DIR_DOWN = 1'b0 constants, also used by the counter and its bench;
  - a count_max(WIDTH) constant function.
- One natural sub-module, sat_counter (parameterised width, inc, sync clear, async reset), used for wrap_count.
- Everything else lives inline.

Test Plan:
1. Reset, then up_down = 1, count_in runs 0..15,0,1 -> after IDLE arm, wrap_pulse = 1 with wrap_up = 1 exactly one clock after count_in = 0 appears; wrap_count = 1, min_seen = 0, max_seen = 15, step_error = 0.
2. up_down = 0, count_in runs 2,1,0,15,14 -> single wrap_pulse with wrap_up = 0; wrap_count increments by 1.
3. Count at 12 going up, flip up_down to 0 -> dir_change pulses for one cycle; count 13->12 is legal; step_error stays 0.
4. Inject a jump 5 -> 9 -> step_error = 1 and stays 1 through 20 further legal steps; clear_stats -> step_error = 0, wrap_count = 0, state IDLE.
5. Count 15 going up, assert reset_signal mid-cycle (count goes to 0) -> outputs clear asynchronously; no wrap_pulse after release; the next sample re-arms with min_seen = max_seen = 0.
6. Force 300 up-wraps with WRAP_CNT_W = 8 -> wrap_count saturates at 255; wrap_pulse still fires on every wrap. Assert clear_stats in the same cycle as a wrap -> no pulse, wrap_count = 0.

Source files
------------

// File: rtl/count_wrap_monitor_pkg.sv
// count_wrap_monitor_pkg: shared state enum, direction constants and count range helper
package count_wrap_monitor_pkg;
    typedef enum logic {IDLE, TRACK} state_t;
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
    function automatic int count_max(input int width);
        return (1 << width) - 1;
    endfunction
endpackage

// File: rtl/count_wrap_monitor_sat_counter.sv
// sat_counter: up counter with synchronous clear that holds at all-ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else if (clr) q <= '0;
        else if (inc && q != '1) q <= q + W'(1);
endmodule

// File: rtl/count_wrap_monitor.sv
// count_wrap_monitor: observes an up/down counter for wraps, direction changes, range and illegal steps
module count_wrap_monitor
    import count_wrap_monitor_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int WRAP_CNT_W = 8
) (
    input  logic                  clock_signal,
    input  logic                  reset_signal,
    input  logic                  up_down,
    input  logic [WIDTH-1:0]      count_in,
    input  logic                  clear_stats,
    output logic                  wrap_pulse,
    output logic                  wrap_up,
    output logic                  dir_change,
    output logic [WRAP_CNT_W-1:0] wrap_count,
    output logic [WIDTH-1:0]      min_seen,
    output logic [WIDTH-1:0]      max_seen,
    output logic                  step_error
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(count_max(WIDTH));
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    state_t state, state_nx;
    logic [WIDTH-1:0] prev_count;
    logic prev_dir, tracking, up_evt, dn_evt, wrap_evt, legal;
    always_comb begin
        tracking = state == TRACK;
        up_evt = tracking && prev_dir == DIR_UP && prev_count == MAX && count_in == '0;
        dn_evt = tracking && prev_dir == DIR_DOWN && prev_count == '0 && count_in == MAX;
        wrap_evt = up_evt || dn_evt;
        legal = count_in == prev_count ||
                count_in == (prev_dir == DIR_UP ? prev_count + ONE : prev_count - ONE);
        state_nx = clear_stats ? IDLE : TRACK;
    end
    always_ff @(posedge clock_signal or posedge reset_signal)
        if (reset_signal) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge clock_signal or posedge reset_signal)
        if (reset_signal || clear_stats) begin
            prev_count <= '0;
            prev_dir <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_up <= 1'b0;
            dir_change <= 1'b0;
            step_error <= 1'b0;
            min_seen <= '0;
            max_seen <= '0;
        end else begin
            prev_count <= count_in;
            prev_dir <= up_down;
            wrap_pulse <= wrap_evt;
            wrap_up <= up_evt;
            dir_change <= tracking && up_down != prev_dir;
            step_error <= step_error || (tracking && !legal);
            min_seen <= !tracking || count_in < min_seen ? count_in : min_seen;
            max_seen <= !tracking || count_in > max_seen ? count_in : max_seen;
        end
    sat_counter #(.W(WRAP_CNT_W)) u_wrap_cnt (
        .clk(clock_signal),
        .rst(reset_signal),
        .inc(wrap_evt && !clear_stats),
        .clr(clear_stats),
        .q(wrap_count)
    );
endmodule

// File: tb/tb_count_wrap_monitor.sv
// tb_count_wrap_monitor: table vectors, directed corner sequences and random stimulus against a rule-level model
module tb_count_wrap_monitor;
    import count_wrap_monitor_pkg::*;
    logic clock_signal = 1'b0, reset_signal = 1'b1, up_down = 1'b0, clear_stats = 1'b0;
    logic [3:0] count_in = 4'd0;
    logic wrap_pulse, wrap_up, dir_change, step_error;
    logic [7:0] wrap_count;
    logic [3:0] min_seen, max_seen;
    count_wrap_monitor dut (
        .clock_signal(clock_signal),
        .reset_signal(reset_signal),
        .up_down(up_down),
        .count_in(count_in),
        .clear_stats(clear_stats),
        .wrap_pulse(wrap_pulse),
        .wrap_up(wrap_up),
        .dir_change(dir_change),
        .wrap_count(wrap_count),
        .min_seen(min_seen),
        .max_seen(max_seen),
        .step_error(step_error)
    );
    always #5 clock_signal = ~clock_signal;
    typedef struct {
        int ud, cnt, clr, pulse, up, dc, wc, mn, mx, err;
    } vec_t;
    vec_t tbl[$];
    int tests = 0, fails = 0;
    bit armed, p_dir, m_err, m_pulse, m_up, m_dc;
    bit seen[16];
    int p_cnt, m_wraps;
    function automatic int m_min();
        if (!armed) return 0;
        for (int v = 0; v < 16; v++) if (seen[v]) return v;
        return 0;
    endfunction
    function automatic int m_max();
        if (!armed) return 0;
        for (int v = 15; v >= 0; v--) if (seen[v]) return v;
        return 0;
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask
    task automatic model_clear();
        armed = 0;
        for (int v = 0; v < 16; v++) seen[v] = 0;
        m_wraps = 0; m_err = 0; m_pulse = 0; m_up = 0; m_dc = 0; p_cnt = 0; p_dir = 0;
    endtask
    task automatic model_step(input bit ud, input int c, input bit clr);
        int delta;
        bit wrap;
        if (clr) model_clear();
        else if (!armed) begin
            model_clear();
            armed = 1; seen[c] = 1; p_cnt = c; p_dir = ud;
        end else begin
            delta = (c - p_cnt + 16) % 16;
            wrap = (p_dir == DIR_UP && p_cnt == 15 && c == 0) || (p_dir == DIR_DOWN && p_cnt == 0 && c == 15);
            m_pulse = wrap;
            m_up = wrap && p_dir == DIR_UP;
            m_dc = ud != p_dir;
            if (!(delta == 0 || (p_dir == DIR_UP && delta == 1) || (p_dir == DIR_DOWN && delta == 15))) m_err = 1;
            if (wrap && m_wraps < 255) m_wraps++;
            seen[c] = 1; p_cnt = c; p_dir = ud;
        end
    endtask
    task automatic check_model(input string tag);
        chk({tag, ".wrap_pulse"}, 32'(wrap_pulse), 32'(m_pulse));
        if (m_pulse) chk({tag, ".wrap_up"}, 32'(wrap_up), 32'(m_up));
        chk({tag, ".dir_change"}, 32'(dir_change), 32'(m_dc));
        chk({tag, ".wrap_count"}, 32'(wrap_count), 32'(m_wraps));
        chk({tag, ".min_seen"}, 32'(min_seen), 32'(m_min()));
        chk({tag, ".max_seen"}, 32'(max_seen), 32'(m_max()));
        chk({tag, ".step_error"}, 32'(step_error), 32'(m_err));
    endtask
    task automatic tick(input int ud, input int c, input int clr, input string tag);
        up_down = ud[0]; count_in = 4'(c); clear_stats = clr[0];
        @(posedge clock_signal);
        model_step(ud[0], c, clr[0]);
        #1;
        check_model(tag);
    endtask
    task automatic async_reset(input string tag);
        reset_signal = 1'b1;
        model_clear();
        #1;
        check_model(tag);
        count_in = 4'd0;
        @(negedge clock_signal);
        reset_signal = 1'b0;
    endtask
    initial begin
        int cur, ud, clr, r, pulses;
        for (int i = 0; i < 16; i++) tbl.push_back('{1, i, 0, 0, 0, 0, 0, 0, i, 0});
        tbl.push_back('{1, 0, 0, 1, 1, 0, 1, 0, 15, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 1, 0, 15, 0});
        tbl.push_back('{0, 2, 0, 0, 0, 1, 1, 0, 15, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 1, 0, 15, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 0, 15, 0});
        tbl.push_back('{0, 15, 0, 1, 0, 0, 2, 0, 15, 0});
        tbl.push_back('{0, 14, 0, 0, 0, 0, 2, 0, 15, 0});
        model_clear();
        #3;
        chk("reset.wrap_pulse", 32'(wrap_pulse), 0);
        chk("reset.dir_change", 32'(dir_change), 0);
        chk("reset.wrap_count", 32'(wrap_count), 0);
        chk("reset.min_max", {min_seen, max_seen}, 0);
        chk("reset.step_error", 32'(step_error), 0);
        @(negedge clock_signal);
        reset_signal = 1'b0;
        foreach (tbl[i]) begin
            tick(tbl[i].ud, tbl[i].cnt, tbl[i].clr, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.pulse", i), 32'(wrap_pulse), tbl[i].pulse);
            if (tbl[i].pulse != 0) chk($sformatf("vec%0d.up", i), 32'(wrap_up), tbl[i].up);
            chk($sformatf("vec%0d.dc", i), 32'(dir_change), tbl[i].dc);
            chk($sformatf("vec%0d.wc", i), 32'(wrap_count), tbl[i].wc);
            chk($sformatf("vec%0d.min", i), 32'(min_seen), tbl[i].mn);
            chk($sformatf("vec%0d.max", i), 32'(max_seen), tbl[i].mx);
            chk($sformatf("vec%0d.err", i), 32'(step_error), tbl[i].err);
        end
        tick(1, 14, 0, "pre_rst");
        tick(1, 15, 0, "pre_rst");
        async_reset("mid_rst");
        chk("mid_rst.wrap_count", 32'(wrap_count), 0);
        tick(1, 0, 0, "rearm");
        chk("rearm.no_pulse", 32'(wrap_pulse), 0);
        chk("rearm.min_max", {min_seen, max_seen}, 0);
        tick(1, 12, 1, "dir_clr");
        tick(1, 12, 0, "dir");
        tick(1, 13, 0, "dir");
        tick(0, 13, 0, "dir_flip");
        chk("dir_flip.pulse", 32'(dir_change), 1);
        tick(0, 12, 0, "dir_after");
        chk("dir_after.pulse", 32'(dir_change), 0);
        chk("dir_after.err", 32'(step_error), 0);
        tick(1, 5, 1, "jump_clr");
        tick(1, 5, 0, "jump_arm");
        tick(1, 9, 0, "jump");
        chk("jump.err", 32'(step_error), 1);
        cur = 9;
        for (int k = 0; k < 20; k++) begin
            cur = (cur + 1) % 16;
            tick(1, cur, 0, "sticky");
        end
        chk("sticky.err", 32'(step_error), 1);
        tick(1, (cur + 1) % 16, 1, "jump_clear");
        chk("jump_clear.err", 32'(step_error), 0);
        chk("jump_clear.wc", 32'(wrap_count), 0);
        tick(1, 7, 0, "idle_arm");
        chk("idle_arm.err", 32'(step_error), 0);
        chk("idle_arm.min_max", {min_seen, max_seen}, {4'd7, 4'd7});
        tick(1, 0, 1, "sat_clr");
        tick(1, 0, 0, "sat_arm");
        pulses = 0;
        for (int w = 0; w < 300; w++) begin
            for (int v = 1; v < 16; v++) tick(1, v, 0, "sat");
            tick(1, 0, 0, "sat_wrap");
            if (wrap_pulse === 1'b1) pulses++;
        end
        chk("sat.pulses", pulses, 300);
        chk("sat.wrap_count", 32'(wrap_count), 255);
        for (int v = 1; v < 16; v++) tick(1, v, 0, "sat");
        tick(1, 0, 1, "clr_wrap");
        chk("clr_wrap.pulse", 32'(wrap_pulse), 0);
        chk("clr_wrap.wc", 32'(wrap_count), 0);
        cur = 0; ud = 1;
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 199));
            if (r < 140) cur = ud != 0 ? (cur + 1) % 16 : (cur + 15) % 16;
            else if (r < 190) cur = int'($urandom_range(0, 15));
            else if (r == 199) begin
                async_reset("rnd_rst");
                cur = 0;
            end
            if ($urandom_range(0, 9) == 0) ud = 1 - ud;
            clr = $urandom_range(0, 49) == 0 ? 1 : 0;
            tick(ud, cur, clr, "rnd");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
